// File: rtl/fifo_wr_packer.sv
// Packs Ratio InW-bit beats LSB-first into one OutW-bit word for the async FIFO write port; word valid 1 cycle after its last beat.
// in_ready_o is built from registered state only, so a stalled output costs one bubble after it drains.
module fifo_wr_packer #(
    parameter  int InW        = 8,
    parameter  int Ratio      = 4,
    parameter  int TimeoutCyc = 16,
    localparam int OutW       = InW * Ratio,
    localparam int CntW       = $clog2(Ratio + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [InW-1:0]  in_data_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [OutW-1:0] out_data_o,
    output logic [CntW-1:0] out_cnt_o,
    output logic            idle_o
);

    localparam int              TW       = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1;
    localparam logic [CntW-1:0] LAST     = CntW'(Ratio - 1);
    localparam logic [CntW-1:0] FULL     = CntW'(Ratio);
    localparam logic [TW-1:0]   TMO_LAST = TW'((TimeoutCyc > 0) ? TimeoutCyc - 1 : 0);
    localparam bit              TMO_EN   = (TimeoutCyc > 0);

    logic [OutW-1:0] r_acc;
    logic [CntW-1:0] r_cnt;
    logic            r_flush_pend;
    logic [TW-1:0]   r_timer;
    logic [OutW-1:0] r_out_dat;
    logic [CntW-1:0] r_out_cnt;
    logic            r_out_vld;

    logic            w_in_rdy;
    logic            w_acc_fire;
    logic            w_out_free;
    logic            w_full_load;
    logic            w_part_load;
    logic            w_tmo;
    logic [OutW-1:0] w_acc_wr;
    logic [OutW-1:0] w_part;

    assign w_in_rdy    = !r_flush_pend && !((r_cnt == LAST) && r_out_vld);
    assign w_acc_fire  = in_valid_i && w_in_rdy;
    assign w_out_free  = !r_out_vld || out_ready_i;
    // A last beat is only accepted when the output register is empty, so no free check is needed here.
    assign w_full_load = w_acc_fire && (r_cnt == LAST);
    assign w_part_load = r_flush_pend && (r_cnt != '0) && w_out_free;
    assign w_tmo       = TMO_EN && (r_cnt != '0) && !w_acc_fire && !r_flush_pend
                         && (r_timer == TMO_LAST);

    always_comb begin
        w_acc_wr = r_acc;
        w_part   = '0;
        for (int k = 0; k < Ratio; k++) begin
            if (CntW'(k) == r_cnt) w_acc_wr[k*InW +: InW] = in_data_i;
            if (CntW'(k) < r_cnt)  w_part[k*InW +: InW]   = r_acc[k*InW +: InW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_full_load || w_part_load) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_acc_fire) begin
            r_acc <= w_acc_wr;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A flush request with nothing held simply retires on the following edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flush_pend <= 1'b0;
        end else if (flush_i || w_tmo) begin
            r_flush_pend <= 1'b1;
        end else if (r_flush_pend && ((r_cnt == '0) || w_part_load)) begin
            r_flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timer <= '0;
        end else if (w_acc_fire || (r_cnt == '0) || r_flush_pend || w_tmo) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_dat <= '0;
            r_out_cnt <= '0;
            r_out_vld <= 1'b0;
        end else if (w_full_load) begin
            r_out_dat <= w_acc_wr;
            r_out_cnt <= FULL;
            r_out_vld <= 1'b1;
        end else if (w_part_load) begin
            r_out_dat <= w_part;
            r_out_cnt <= r_cnt;
            r_out_vld <= 1'b1;
        end else if (out_ready_i) begin
            r_out_vld <= 1'b0;
        end
    end

    assign in_ready_o  = w_in_rdy;
    assign out_valid_o = r_out_vld;
    assign out_data_o  = r_out_dat;
    assign out_cnt_o   = r_out_cnt;
    assign idle_o      = (r_cnt == '0) && !r_flush_pend && !r_out_vld;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: per-cycle vector table plus backpressure and timeout sequences.
module tb_fifo_wr_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld, flush, ordy;
    logic [7:0]  dat;
    logic        in_rdy, out_vld, idle;
    logic [31:0] out_dat;
    logic [2:0]  out_cnt;

    logic        n_vld;
    logic [7:0]  n_dat;
    logic        n_in_rdy, n_out_vld, n_idle;
    logic [31:0] n_out_dat;
    logic [2:0]  n_out_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] words[$];

    always #5 clk = ~clk;

    fifo_wr_packer #(.InW(8), .Ratio(4), .TimeoutCyc(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(vld), .in_ready_o(in_rdy), .in_data_i(dat),
        .flush_i(flush),
        .out_valid_o(out_vld), .out_ready_i(ordy), .out_data_o(out_dat), .out_cnt_o(out_cnt),
        .idle_o(idle)
    );

    fifo_wr_packer #(.InW(8), .Ratio(4), .TimeoutCyc(0)) dut_notmo (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(n_vld), .in_ready_o(n_in_rdy), .in_data_i(n_dat),
        .flush_i(1'b0),
        .out_valid_o(n_out_vld), .out_ready_i(1'b1), .out_data_o(n_out_dat), .out_cnt_o(n_out_cnt),
        .idle_o(n_idle)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        exp_rdy;
        logic        exp_ovld;
        logic [31:0] exp_odat;
        logic [2:0]  exp_ocnt;
        logic        exp_idle;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic f,
                       input logic rdy, input logic ov, input logic [31:0] od,
                       input logic [2:0] oc, input logic idl);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.f = f;
        e.exp_rdy = rdy; e.exp_ovld = ov; e.exp_odat = od; e.exp_ocnt = oc; e.exp_idle = idl;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Records any word handed to the FIFO at the coming edge, then advances one cycle.
    task automatic cyc();
        if (out_vld && ordy) words.push_back(out_dat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int w;
        int first;
        logic [31:0] got_dat;
        logic [2:0]  got_cnt;
        logic        n_seen;

        rst = 1'b1; vld = 1'b0; dat = '0; flush = 1'b0; ordy = 1'b1;
        n_vld = 1'b0; n_dat = '0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_in_rdy",  32'(in_rdy), 1);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_cnt", 32'(out_cnt), 0);
        chk("rst_idle",    32'(idle), 1);
        chk("rst_idle_n",  32'(n_idle), 1);

        //   r  v  dat    f  rdy ov  odat          oc idle
        add(0, 1, 8'h11, 0, 1, 0, 32'h0,        0, 0);
        add(0, 1, 8'h22, 0, 1, 0, 32'h0,        0, 0);
        add(0, 1, 8'h33, 0, 1, 0, 32'h0,        0, 0);
        add(0, 1, 8'h44, 0, 1, 1, 32'h44332211, 4, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h44332211, 4, 1);
        add(0, 1, 8'hAA, 0, 1, 0, 32'h44332211, 4, 0);
        add(0, 1, 8'hBB, 0, 1, 0, 32'h44332211, 4, 0);
        add(0, 0, 8'h00, 1, 1, 0, 32'h44332211, 4, 0);
        add(0, 0, 8'h00, 0, 0, 1, 32'h0000BBAA, 2, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0000BBAA, 2, 1);
        add(0, 0, 8'h00, 1, 1, 0, 32'h0000BBAA, 2, 0);
        add(0, 0, 8'h00, 0, 0, 0, 32'h0000BBAA, 2, 1);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0000BBAA, 2, 1);
        add(0, 1, 8'hAA, 0, 1, 0, 32'h0000BBAA, 2, 0);
        add(0, 1, 8'hCC, 1, 1, 0, 32'h0000BBAA, 2, 0);
        add(0, 0, 8'h00, 0, 0, 1, 32'h0000CCAA, 2, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h0000CCAA, 2, 1);
        add(0, 1, 8'h01, 0, 1, 0, 32'h0000CCAA, 2, 0);
        add(0, 1, 8'h02, 0, 1, 0, 32'h0000CCAA, 2, 0);
        add(0, 1, 8'h03, 0, 1, 0, 32'h0000CCAA, 2, 0);
        add(1, 0, 8'h00, 0, 1, 0, 32'h0,        0, 1);
        add(0, 1, 8'h05, 0, 1, 0, 32'h0,        0, 0);
        add(0, 1, 8'h06, 0, 1, 0, 32'h0,        0, 0);
        add(0, 1, 8'h07, 0, 1, 0, 32'h0,        0, 0);
        add(0, 1, 8'h08, 0, 1, 1, 32'h08070605, 4, 0);
        add(0, 0, 8'h00, 0, 1, 0, 32'h08070605, 4, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; vld = tbl[i].v; dat = tbl[i].d; flush = tbl[i].f;
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].exp_rdy));
            cyc();
            chk($sformatf("v%0d_out_vld", i), 32'(out_vld), 32'(tbl[i].exp_ovld));
            chk($sformatf("v%0d_out_dat", i), out_dat, tbl[i].exp_odat);
            chk($sformatf("v%0d_out_cnt", i), 32'(out_cnt), 32'(tbl[i].exp_ocnt));
            chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tbl[i].exp_idle));
        end
        rst = 1'b0; vld = 1'b0; flush = 1'b0;

        // Backpressure: eight beats into a stalled output, then release.
        ordy = 1'b0;
        words.delete();
        for (int i = 0; i < 8; i++) begin
            vld = 1'b1;
            dat = 8'(i + 1);
            if (i == 7) begin
                chk("bp_rdy_drop", 32'(in_rdy), 0);
                repeat (3) begin
                    cyc();
                    chk("bp_hold_vld", 32'(out_vld), 1);
                    chk("bp_hold_dat", out_dat, 32'h04030201);
                    chk("bp_hold_cnt", 32'(out_cnt), 4);
                end
                ordy = 1'b1;
            end
            w = 0;
            while (!in_rdy && w < 20) begin
                cyc();
                w++;
            end
            chk($sformatf("bp_beat%0d_rdy", i), 32'(in_rdy), 1);
            cyc();
        end
        vld = 1'b0;
        w = 0;
        while (words.size() < 2 && w < 20) begin
            cyc();
            w++;
        end
        chk("bp_nwords", 32'(words.size()), 2);
        if (words.size() >= 2) begin
            chk("bp_word0", words[0], 32'h04030201);
            chk("bp_word1", words[1], 32'h08070605);
        end
        chk("bp_idle", 32'(idle), 1);

        // Timeout: one beat then idle; the TimeoutCyc=0 instance must hold its partial word.
        vld = 1'b1; dat = 8'h5A;
        n_vld = 1'b1; n_dat = 8'h5A;
        cyc();
        vld = 1'b0; n_vld = 1'b0;
        first = -1; got_dat = '0; got_cnt = '0; n_seen = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            cyc();
            if (first < 0 && out_vld) begin
                first   = c;
                got_dat = out_dat;
                got_cnt = out_cnt;
            end
            if (n_out_vld) n_seen = 1'b1;
        end
        chk("tmo_cycles", first, 17);
        chk("tmo_dat", got_dat, 32'h0000005A);
        chk("tmo_cnt", 32'(got_cnt), 1);
        chk("tmo_idle_after", 32'(idle), 1);
        chk("notmo_no_out", 32'(n_seen), 0);
        chk("notmo_not_idle", 32'(n_idle), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
